// File: rtl/fp_sort_engine.sv
// Batch bubble sorter: loads N sign-magnitude floats, sorts in place with one
// compare per cycle, then streams them out in order.
module fp_sort_engine #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         descending,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [7:0]   swap_cnt
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_UNLOAD} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]  pass_q, pass_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [W-1:0]   mem_q [N];
    logic [W-1:0]   mem_d [N];
    logic [7:0]     swap_cnt_q, swap_cnt_d;
    logic           desc_q, desc_d;
    logic           swapped_q, swapped_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;

    logic [CW-1:0]  idx_nxt;
    logic [W-1:0]   cmp_a, cmp_b;
    logic           do_swap;
    logic           last_idx;

    // Strict greater-than; +0 and -0 compare equal.
    function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-2:0] ma;
        logic [W-2:0] mb;
        ma = a[W-2:0];
        mb = b[W-2:0];
        if (ma == '0 && mb == '0)
            gt = 1'b0;
        else if (a[W-1] != b[W-1])
            gt = ~a[W-1];
        else if (!a[W-1])
            gt = (ma > mb);
        else
            gt = (ma < mb);
    endfunction

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pass_d     = pass_q;
        idx_d      = idx_q;
        mem_d      = mem_q;
        swap_cnt_d = swap_cnt_q;
        desc_d     = desc_q;
        swapped_d  = swapped_q;

        idx_nxt  = idx_q + CW'(1);
        cmp_a    = mem_q[idx_q];
        cmp_b    = mem_q[idx_nxt];
        do_swap  = desc_q ? gt(cmp_b, cmp_a) : gt(cmp_a, cmp_b);
        last_idx = (CW'(idx_q + pass_q) == CW'(N - 2));

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_cnt_q] = in_data;
                    if (wr_cnt_q == CW'(N - 1)) begin
                        state_d    = S_SORT;
                        desc_d     = descending;
                        swap_cnt_d = 8'd0;
                        pass_d     = '0;
                        idx_d      = '0;
                        swapped_d  = 1'b0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            S_SORT: begin
                if (do_swap) begin
                    mem_d[idx_q]   = cmp_b;
                    mem_d[idx_nxt] = cmp_a;
                    swapped_d      = 1'b1;
                    if (swap_cnt_q != 8'hFF)
                        swap_cnt_d = swap_cnt_q + 8'd1;
                end
                if (last_idx) begin
                    // Early exit when a full pass made no swap.
                    if (!(swapped_q || do_swap) || pass_q == CW'(N - 2)) begin
                        state_d  = S_UNLOAD;
                        rd_cnt_d = '0;
                    end else begin
                        pass_d    = pass_q + CW'(1);
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_nxt;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (rd_cnt_q == CW'(N - 1)) begin
                        state_d  = S_LOAD;
                        wr_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_SORT);
        out_valid_d = (state_d == S_UNLOAD);
        out_data_d  = out_valid_d ? mem_d[rd_cnt_d] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pass_q      <= '0;
            idx_q       <= '0;
            for (int i = 0; i < int'(N); i++)
                mem_q[i] <= '0;
            swap_cnt_q  <= 8'd0;
            desc_q      <= 1'b0;
            swapped_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pass_q      <= pass_d;
            idx_q       <= idx_d;
            mem_q       <= mem_d;
            swap_cnt_q  <= swap_cnt_d;
            desc_q      <= desc_d;
            swapped_q   <= swapped_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_fp_sort_engine.sv
// Scoreboard bench for fp_sort_engine: directed batches, expected order queued
// at load time and checked by an independent output monitor.
module tb_fp_sort_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        descending = 1'b0;
    logic [12:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic [7:0]  swap_cnt;

    fp_sort_engine #(.N(8), .W(13)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .descending(descending),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .swap_cnt(swap_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int busy_cyc = 0;
    logic [12:0] sb[$];
    logic        stalled_prev = 1'b0;
    logic [12:0] data_prev = '0;

    logic [12:0] d_mix  [8] = '{13'h0AD7, 13'h1AAA, 13'h0AAA, 13'h1AD7, 13'h0DD4, 13'h0000, 13'h1000, 13'h00AE};
    logic [12:0] e_asc  [8] = '{13'h1AD7, 13'h1AAA, 13'h0000, 13'h1000, 13'h00AE, 13'h0AAA, 13'h0AD7, 13'h0DD4};
    logic [12:0] e_desc [8] = '{13'h0DD4, 13'h0AD7, 13'h0AAA, 13'h00AE, 13'h0000, 13'h1000, 13'h1AAA, 13'h1AD7};
    logic [12:0] d_srt  [8] = '{13'h1AD7, 13'h1AAA, 13'h0000, 13'h00AE, 13'h00DC, 13'h0AAA, 13'h0AD7, 13'h0E86};
    logic [12:0] d_rev  [8] = '{13'h0E86, 13'h0AD7, 13'h0AAA, 13'h00DC, 13'h00AE, 13'h0000, 13'h1AAA, 13'h1AD7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: protocol checks and scoreboard pops, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (busy) busy_cyc++;
            if (busy || out_valid) chk("in_ready_low", 32'(in_ready), 32'd0);
            if (!out_valid) chk("out_data_idle", 32'(out_data), 32'd0);
            if (stalled_prev && out_valid) chk("stall_hold", 32'(out_data), 32'(data_prev));
            stalled_prev = out_valid && !out_ready;
            data_prev = out_data;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got 0x%0h, want no output", out_data);
                end else begin
                    chk("unload", 32'(out_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic load(input logic [12:0] w[8], input logic desc, input bit gaps,
                        input bit keep, input int gate_hs);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < 8) begin
            in_data    = w[i];
            descending = desc;
            in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc && i == 0 && gate_hs >= 0) chk("b2b_gate", 32'(hs_cnt), 32'(gate_hs));
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
            if (guard > 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL load_timeout: got %0d words, want 8", i);
                break;
            end
        end
        in_valid = keep;
    endtask

    task automatic push_exp(input logic [12:0] e[8]);
        for (int k = 0; k < 8; k++) sb.push_back(e[k]);
    endtask

    task automatic wait_hs(input int target);
        int guard = 0;
        while (hs_cnt < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (hs_cnt < target) begin
            n_vec++;
            n_err++;
            $display("FAIL unload_timeout: got %0d handshakes, want %0d", hs_cnt, target);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_swap_cnt", 32'(swap_cnt), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ascending mixed data
        load(d_mix, 1'b0, 1'b0, 1'b0, -1);
        push_exp(e_asc);
        wait_hs(8);

        // 2: descending mixed data
        load(d_mix, 1'b1, 1'b0, 1'b0, -1);
        push_exp(e_desc);
        wait_hs(16);

        // 3a: already sorted
        busy_cyc = 0;
        load(d_srt, 1'b0, 1'b0, 1'b0, -1);
        push_exp(d_srt);
        wait_hs(24);
        chk("sorted_busy", 32'(busy_cyc), 32'd7);
        chk("sorted_swaps", 32'(swap_cnt), 32'd0);

        // 3b: reverse sorted
        busy_cyc = 0;
        load(d_rev, 1'b0, 1'b0, 1'b0, -1);
        push_exp(d_srt);
        wait_hs(32);
        chk("reverse_busy", 32'(busy_cyc), 32'd28);
        chk("reverse_swaps", 32'(swap_cnt), 32'd28);

        // 4: input gaps and an output stall
        load(d_mix, 1'b0, 1'b1, 1'b0, -1);
        push_exp(e_asc);
        base = hs_cnt;
        while (hs_cnt < base + 3) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_hs(base + 8);

        // 5: asynchronous reset on the third sort cycle
        load(d_rev, 1'b0, 1'b0, 1'b0, -1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_swap_cnt", 32'(swap_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        base = hs_cnt;
        load(d_mix, 1'b0, 1'b0, 1'b0, -1);
        push_exp(e_asc);
        wait_hs(base + 8);

        // 6: back-to-back batches with in_valid held high
        base = hs_cnt;
        load(d_mix, 1'b0, 1'b0, 1'b1, -1);
        push_exp(e_asc);
        load(d_srt, 1'b1, 1'b0, 1'b0, base + 8);
        push_exp(d_rev);
        wait_hs(base + 16);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
